compare_unit: RTL and testbench
===============================

COMPARE_UNIT -- requirements
Module: compare_unit

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Parameter RD_WIDTH, default 3, result width in bits; result is 0 or 1 zero-extended to RD_WIDTH.
REQ-003 Parameter CNT_WIDTH, default 8, width of the true-result counter.
REQ-004 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port in_valid, input, 1, opcode/R1/R2 presented this cycle.
REQ-007 Port in_ready, output, 1, unit accepts a compare this cycle.
REQ-008 Port opcode, input, 5, compare select: LT=01011, GT=01100, EQ=01101, GTE=01110, LTE=01111, NE=10000.
REQ-009 Port R1, input, WIDTH, first operand.
REQ-010 Port R2, input, WIDTH, second operand.
REQ-011 Port out_valid, output, 1, RD/err hold a completed result.
REQ-012 Port out_ready, input, 1, consumer takes the result this cycle.
REQ-013 Port RD, output, RD_WIDTH, compare result (1 = condition true).
REQ-014 Port err, output, 1, result came from an opcode outside the six listed.
REQ-015 Port true_cnt, output, CNT_WIDTH, number of delivered results with RD=1, saturating.

Function
REQ-016 Accept = in_valid & in_ready; deliver = out_valid & out_ready.
REQ-017 Two registered stages: S1 captures opcode/R1/R2 on accept; S2 holds computed RD/err; latency accept -> out_valid = 2 cycles with no backpressure.
REQ-018 S1 advances to S2 when S2 empty or delivering in the same cycle; in_ready = ~S1 valid | S1 advancing.
REQ-019 Full throughput: with out_ready held 1, one accept and one deliver per cycle sustained.
REQ-020 Backpressure: out_ready=0 holds RD, err, out_valid stable; S1 fills, then in_ready=0; no result lost or duplicated.
REQ-021 Inputs not sampled when accept is 0; R1/R2/opcode changes while in_ready=0 have no effect.
REQ-022 Compare is unsigned over WIDTH bits unless REQ-030 applies.
REQ-023 Unknown opcode: RD=0, err=1; otherwise err=0.
REQ-024 true_cnt increments by 1 on each deliver with RD[0]=1; holds at 2^CNT_WIDTH-1, no wrap.
REQ-025 Results delivered in accept order; no reordering.

Reset
REQ-026 Reset asserted: S1 valid=0, S2 valid=0, in_ready=0, out_valid=0, RD=0, err=0, true_cnt=0, immediately without clock.
REQ-027 Reset mid-operation discards in-flight compares in S1 and S2; none delivered after release.
REQ-028 First rising edge after reset deassertion: in_ready=1; accept possible that edge.

Configuration
REQ-029 Macro CMP_SIGNED_EN selects signed-compare support.
REQ-030 With CMP_SIGNED_EN defined: extra input port sgn (1 bit) captured with opcode in S1; sgn=1 makes LT/GT/GTE/LTE two's-complement over WIDTH bits; EQ/NE unaffected.
REQ-031 Without CMP_SIGNED_EN: port sgn absent; all compares unsigned.

Verification
REQ-032 WIDTH=8, LT R1=3 R2=5 accepted cycle 0, out_ready=1 -> cycle 2 out_valid=1 RD=001 err=0, true_cnt=1 after deliver.
REQ-033 Back-to-back EQ 7/7, NE 7/7, GTE 0/255, LTE 255/255 -> RD 1,0,0,1 on consecutive cycles, in_ready stays 1.
REQ-034 out_ready=0 with three accepts attempted -> two accepted, in_ready=0 on third, RD frozen; release out_ready -> results in order, none lost.
REQ-035 opcode 00000 R1=1 R2=1 -> RD=000 err=1, true_cnt unchanged.
REQ-036 CMP_SIGNED_EN, sgn=1, LT R1=8'hFF R2=8'h01 -> RD=1; sgn=0 same operands -> RD=0.
REQ-037 Reset pulse while S1 and S2 valid -> out_valid=0 and true_cnt=0 asynchronously; no delivery after release; CNT_WIDTH=2, five true results -> true_cnt=3.

Source files
------------

// File: rtl/compare_unit_if.sv
// Handshake bundle for compare_unit: request side (opcode/R1/R2), result side (RD/err).
// CMP_SIGNED_EN adds the sgn request field.
interface compare_unit_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RD_WIDTH  = 3,
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           opcode;
  logic [WIDTH-1:0]     R1;
  logic [WIDTH-1:0]     R2;
`ifdef CMP_SIGNED_EN
  logic                 sgn;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic [RD_WIDTH-1:0]  RD;
  logic                 err;
  logic [CNT_WIDTH-1:0] true_cnt;

  modport master (
`ifdef CMP_SIGNED_EN
    output sgn,
`endif
    output in_valid, opcode, R1, R2, out_ready,
    input  in_ready, out_valid, RD, err, true_cnt
  );

  modport slave (
`ifdef CMP_SIGNED_EN
    input  sgn,
`endif
    input  in_valid, opcode, R1, R2, out_ready,
    output in_ready, out_valid, RD, err, true_cnt
  );
endinterface

// File: rtl/compare_unit.sv
// Two-stage pipelined comparator with valid/ready on both sides and a saturating true counter.
// Define CMP_SIGNED_EN to add the sgn field selecting two's-complement ordering compares.
module compare_unit #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RD_WIDTH  = 3,
  parameter int unsigned CNT_WIDTH = 8
) (
  input logic            clk,
  input logic            reset,
  compare_unit_if.slave  bus
);

  typedef enum logic [4:0] {
    OpLt  = 5'b01011,
    OpGt  = 5'b01100,
    OpEq  = 5'b01101,
    OpGte = 5'b01110,
    OpLte = 5'b01111,
    OpNe  = 5'b10000
  } opcode_e;

  // Stage 1: captured request
  logic             s1_valid_q, s1_valid_d;
  logic [4:0]       s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
`ifdef CMP_SIGNED_EN
  logic             s1_sgn_q;
`endif

  // Stage 2: computed result
  logic                 s2_valid_q, s2_valid_d;
  logic [RD_WIDTH-1:0]  rd_q, rd_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic accept;
  logic deliver;
  logic s1_adv;
  logic in_ready;

  logic lt, gt, eq;
  logic res_bit;
  logic res_err;

  // Handshake and pipeline advance
  always_comb begin
    deliver    = s2_valid_q & bus.out_ready;
    s1_adv     = s1_valid_q & (~s2_valid_q | deliver);
    // Held low while reset is asserted so nothing is offered to the producer.
    in_ready   = ~reset & (~s1_valid_q | s1_adv);
    accept     = bus.in_valid & in_ready;
    s1_valid_d = accept | (s1_valid_q & ~s1_adv);
    s2_valid_d = s1_adv | (s2_valid_q & ~deliver);
  end

  // Relational evaluation on the stage-1 operands
  always_comb begin
    eq = (s1_a_q == s1_b_q);
`ifdef CMP_SIGNED_EN
    if (s1_sgn_q) begin
      lt = ($signed(s1_a_q) < $signed(s1_b_q));
      gt = ($signed(s1_a_q) > $signed(s1_b_q));
    end else begin
      lt = (s1_a_q < s1_b_q);
      gt = (s1_a_q > s1_b_q);
    end
`else
    lt = (s1_a_q < s1_b_q);
    gt = (s1_a_q > s1_b_q);
`endif
  end

  // Opcode decode; anything outside the six compares yields RD=0 with err set
  always_comb begin
    res_bit = 1'b0;
    res_err = 1'b0;
    case (s1_op_q)
      OpLt:    res_bit = lt;
      OpGt:    res_bit = gt;
      OpEq:    res_bit = eq;
      OpGte:   res_bit = ~lt;
      OpLte:   res_bit = ~gt;
      OpNe:    res_bit = ~eq;
      default: res_err = 1'b1;
    endcase
  end

  // Stage-2 next state and saturating counter
  always_comb begin
    rd_d  = rd_q;
    err_d = err_q;
    cnt_d = cnt_q;
    if (s1_adv) begin
      rd_d  = RD_WIDTH'(res_bit);
      err_d = res_err;
    end
    if (deliver && rd_q[0] && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= 5'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
`ifdef CMP_SIGNED_EN
      s1_sgn_q   <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_op_q <= bus.opcode;
        s1_a_q  <= bus.R1;
        s1_b_q  <= bus.R2;
`ifdef CMP_SIGNED_EN
        s1_sgn_q <= bus.sgn;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      rd_q       <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.RD        = rd_q;
  assign bus.err       = err_q;
  assign bus.true_cnt  = cnt_q;

endmodule

// File: tb/tb_compare_unit.sv
// Directed + randomized bench for compare_unit with a queue scoreboard checked on each delivery.
// A second instance with CNT_WIDTH=2 exercises counter saturation.
module tb_compare_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  compare_unit_if #(.WIDTH(8), .RD_WIDTH(3), .CNT_WIDTH(8)) bus ();
  compare_unit_if #(.WIDTH(8), .RD_WIDTH(3), .CNT_WIDTH(2)) bus2 ();

  compare_unit #(.WIDTH(8), .RD_WIDTH(3), .CNT_WIDTH(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  compare_unit #(.WIDTH(8), .RD_WIDTH(3), .CNT_WIDTH(2)) u_dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_deliv = 0;
  logic [1:0] sb[$];        // {err, rd}
  logic [7:0] cnt_model = 8'd0;

  logic [4:0] optab [8] = '{5'b01011, 5'b01100, 5'b01101, 5'b01110,
                            5'b01111, 5'b10000, 5'b00000, 5'b11111};
  logic [4:0] b2b_op [4] = '{5'b01101, 5'b10000, 5'b01110, 5'b01111};
  logic [7:0] b2b_a  [4] = '{8'd7, 8'd7, 8'd0, 8'd255};
  logic [7:0] b2b_b  [4] = '{8'd7, 8'd7, 8'd255, 8'd255};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model(input logic [4:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic s);
    int sa, sb_i;
    logic below;
    sa   = s ? int'($signed(a)) : int'(a);
    sb_i = s ? int'($signed(b)) : int'(b);
    below = (sa < sb_i);
    case (op)
      5'b01011: return {1'b0, below};
      5'b01100: return {1'b0, sa > sb_i};
      5'b01101: return {1'b0, a == b};
      5'b01110: return {1'b0, !below};
      5'b01111: return {1'b0, sa <= sb_i};
      5'b10000: return {1'b0, a != b};
      default:  return 2'b10;
    endcase
  endfunction

  // Scoreboard: push on accept, pop/compare on deliver, track the counter every cycle
  always @(negedge clk) begin : monitor
    logic [1:0] e;
    logic s_in;
    if (!reset) begin
      check("true_cnt", 32'(bus.true_cnt), 32'(cnt_model));
      if (bus.out_valid && bus.out_ready) begin
        n_deliv++;
        check("result_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rd", 32'(bus.RD), 32'(e[0]));
          check("err", 32'(bus.err), 32'(e[1]));
          if (e[0] && cnt_model != 8'hFF) cnt_model = cnt_model + 8'd1;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
`ifdef CMP_SIGNED_EN
        s_in = bus.sgn;
`else
        s_in = 1'b0;
`endif
        sb.push_back(model(bus.opcode, bus.R1, bus.R2, s_in));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic set_req(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic s);
    bus.opcode = op;
    bus.R1     = a;
    bus.R2     = b;
`ifdef CMP_SIGNED_EN
    bus.sgn    = s;
`else
    if (s) bus.opcode = op;
`endif
    bus.in_valid = 1'b1;
  endtask

  task automatic send(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input bit rnd);
    bit got;
    got = 1'b0;
    set_req(op, a, b, s);
    for (int k = 0; k < 50 && !got; k++) begin
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk);
      #1;
    end
    check("send_accept", 32'(got), 32'd1);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    @(posedge clk);
    #1;
    check("drain_done", 32'(sb.size()), 32'd0);
  endtask

  initial begin : stim
    int base;
    logic [7:0] cnt_before;
    logic [7:0] ra, rb;

    bus.in_valid = 1'b0; bus.opcode = 5'b0; bus.R1 = 8'd0; bus.R2 = 8'd0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.opcode = 5'b0; bus2.R1 = 8'd0; bus2.R2 = 8'd0;
    bus2.out_ready = 1'b1;
`ifdef CMP_SIGNED_EN
    bus.sgn = 1'b0;
    bus2.sgn = 1'b0;
`endif

    // Reset state, no clock edge yet
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_rd", 32'(bus.RD), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_true_cnt", 32'(bus.true_cnt), 32'd0);

    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    set_req(5'b01011, 8'd3, 8'd5, 1'b0);

    // Latency: accept at cycle 0, result visible in cycle 2
    @(negedge clk); check("first_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(negedge clk); check("lat_c1_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_c2_out_valid", 32'(bus.out_valid), 32'd1);
    check("lat_c2_rd", 32'(bus.RD), 32'd1);
    check("lat_c2_err", 32'(bus.err), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); check("lat_true_cnt", 32'(bus.true_cnt), 32'd1);
    @(posedge clk); #1;

    // Back-to-back at full throughput
    base = n_deliv;
    for (int i = 0; i < 4; i++) begin
      set_req(b2b_op[i], b2b_a[i], b2b_b[i], 1'b0);
      @(negedge clk); check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
    end
    drain(20);
    check("b2b_count", 32'(n_deliv - base), 32'd4);

    // Backpressure: two accepted, third stalls with RD frozen
    base = n_deliv;
    bus.out_ready = 1'b0;
    send(5'b01101, 8'd4, 8'd4, 1'b0, 1'b0);
    send(5'b01100, 8'd1, 8'd2, 1'b0, 1'b0);
    set_req(5'b01111, 8'd3, 8'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_rd_frozen", 32'(bus.RD), 32'd1);
      @(posedge clk); #1;
      bus.R1 = 8'd9;   // must not leak into the stalled request
      bus.R1 = 8'd3;
    end
    bus.out_ready = 1'b1;
    send(5'b01111, 8'd3, 8'd3, 1'b0, 1'b0);
    drain(20);
    check("bp_count", 32'(n_deliv - base), 32'd3);

    // Unknown opcodes
    cnt_before = cnt_model;
    send(5'b00000, 8'd1, 8'd1, 1'b0, 1'b0);
    send(5'b11111, 8'd0, 8'd9, 1'b0, 1'b0);
    send(5'b01010, 8'd5, 8'd5, 1'b0, 1'b0);
    drain(20);
    check("unk_cnt_hold", 32'(bus.true_cnt), 32'(cnt_before));

`ifdef CMP_SIGNED_EN
    send(5'b01011, 8'hFF, 8'h01, 1'b1, 1'b0);
    send(5'b01011, 8'hFF, 8'h01, 1'b0, 1'b0);
    send(5'b01100, 8'h80, 8'h7F, 1'b1, 1'b0);
    send(5'b01101, 8'hFF, 8'hFF, 1'b1, 1'b0);
    drain(20);
`endif

    // Randomized mix with random backpressure
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom_range(0, 255));
      send(optab[$urandom_range(0, 7)], ra, rb, 1'($urandom_range(0, 1)), 1'b1);
    end
    drain(100);

    // Counter saturation on the CNT_WIDTH=2 instance
    bus2.opcode = 5'b01011; bus2.R1 = 8'd1; bus2.R2 = 8'd2; bus2.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check("sat_in_ready", 32'(bus2.in_ready), 32'd1);
      @(posedge clk); #1;
    end
    bus2.in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("sat_true_cnt", 32'(bus2.true_cnt), 32'd3);

    // Reset while both stages hold work
    base = n_deliv;
    bus.out_ready = 1'b0;
    send(5'b01101, 8'd2, 8'd2, 1'b0, 1'b0);
    send(5'b01101, 8'd6, 8'd6, 1'b0, 1'b0);
    check("pre_rst_cnt_nonzero", 32'(bus.true_cnt != 0), 32'd1);
    reset = 1'b1;
    sb.delete();
    cnt_model = 8'd0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_true_cnt", 32'(bus.true_cnt), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_rd", 32'(bus.RD), 32'd0);
    check("mid_rst_sat_cnt", 32'(bus2.true_cnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("post_rst_no_delivery", 32'(n_deliv - base), 32'd0);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Pipeline still functional after reset
    send(5'b01110, 8'd9, 8'd3, 1'b0, 1'b0);
    drain(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
